ahb_lite_master: RTL and testbench

- Single-clock AHB-Lite master that drives the memory slave's HADDR/HWDATA/HTRANS/HWRITE/HSEL.
- Converts a valid/ready command stream of single 32-bit word transfers into pipelined AHB address and data phases.
- Returns one response per command (read data plus error flag) through a small response FIFO.
- Sits directly upstream of the memory slave in the VIP/testbench fabric.

---
 rtl/ahb_lite_pkg.sv | 31 +++
 rtl/ahb_rsp_fifo.sv | 78 +++++++
 rtl/ahb_lite_master.sv | 181 ++++++++++++++++++
 tb/tb_ahb_lite_master.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_pkg
//  Description : Shared definitions for the AHB-Lite master: HTRANS encodings,
//                default bus widths and the command / response record types.
//  Revision    : 1.0  initial release
// ============================================================================
package ahb_lite_pkg;

  localparam int AHB_ADDR_W = 10;
  localparam int AHB_DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef struct packed {
    logic                  write;
    logic [AHB_ADDR_W-1:0] addr;
    logic [AHB_DATA_W-1:0] wdata;
  } ahb_cmd_t;

  typedef struct packed {
    logic [AHB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  write;
  } ahb_rsp_t;

endpackage
`default_nettype wire

// File: rtl/ahb_rsp_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_rsp_fifo
//  Description : Synchronous FIFO holding packed response records.
//  Ports       : i_clk      clock
//                i_rst_n    synchronous active-low reset (empties the FIFO)
//                i_push     write i_wdata (ignored when full without a pop)
//                i_wdata    record to store
//                i_pop      consume head entry (ignored when empty)
//                o_rdata    head entry
//                o_valid    FIFO not empty
//                o_count    number of stored entries
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_rsp_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_valid = !w_empty;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ahb_lite_master.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_master
//  Description : AHB-Lite master turning a valid/ready stream of single-word
//                commands into pipelined NONSEQ address/data phases, with one
//                response per command returned through a response FIFO.
//  Option      : define AHB_LITE_MASTER_TIMEOUT_EN to add a wait-state
//                watchdog (parameter TIMEOUT_CYCLES, output rsp_timeout).
//  Ports       : HCLK / HRESETn       clock, synchronous active-low reset
//                cmd_*                command stream (valid/ready)
//                rsp_*                response stream (valid/ready)
//                busy                 address or data phase in flight
//                H*                   AHB-Lite master bus signals
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W         = AHB_ADDR_W,
  parameter int DATA_W         = AHB_DATA_W,
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 16,
`endif
  parameter int RSP_DEPTH      = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_write,
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
  output logic              rsp_timeout,
`endif
  output logic              busy,
  output logic [ADDR_W-1:0] HADDR,
  output logic [DATA_W-1:0] HWDATA,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic              HSEL,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HRESP,
  input  logic              HREADY
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
  localparam int TO_BIT = 1;
`else
  localparam int TO_BIT = 0;
`endif
  // Record layout: {rdata, err, write [, timeout]}
  localparam int RSP_W = DATA_W + 2 + TO_BIT;

  // Address-phase slot
  logic              r_ap_vld;
  logic              r_ap_write;
  logic [ADDR_W-1:0] r_ap_addr;
  logic [DATA_W-1:0] r_ap_wdata;
  // Data-phase slot
  logic              r_dp_vld;
  logic              r_dp_write;
  logic [DATA_W-1:0] r_dp_wdata;

  logic [CNT_W-1:0]  w_fifo_count;
  logic [CNT_W:0]    w_inflight;
  logic              w_accept;
  logic              w_advance;
  logic              w_force;
  logic              w_push;
  logic [DATA_W-1:0] w_push_rdata;
  logic              w_push_err;
  logic [RSP_W-1:0]  w_push_data;
  logic [RSP_W-1:0]  w_head;

`ifdef AHB_LITE_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_wait_cnt;
  logic            r_flush;
  logic            w_expire;

  assign w_expire = r_dp_vld && !HREADY && (r_wait_cnt == TO_W'(TIMEOUT_CYCLES));
  // The FIFO takes one push per cycle, so a pending address phase is retired
  // on the cycle after the data phase (r_flush).
  assign w_force  = w_expire || r_flush;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_wait_cnt <= '0;
      r_flush    <= 1'b0;
    end else begin
      r_flush <= w_expire && r_ap_vld;
      if (HREADY || w_force)
        r_wait_cnt <= '0;
      else if (r_dp_vld)
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  // Count every in-flight transfer against the FIFO so each is guaranteed a
  // slot when it completes.
  assign w_inflight = (CNT_W+1)'(w_fifo_count) + (CNT_W+1)'(r_ap_vld)
                    + (CNT_W+1)'(r_dp_vld);
  assign cmd_ready  = HREADY && !w_force && (w_inflight < (CNT_W+1)'(RSP_DEPTH));
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_advance  = HREADY || w_force;
  assign w_push     = w_advance && r_dp_vld;

  assign w_push_rdata = (r_dp_write || w_force) ? '0 : HRDATA;
  assign w_push_err   = (HRESP && HREADY) || w_force;
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
  assign w_push_data  = {w_push_rdata, w_push_err, r_dp_write, w_force};
`else
  assign w_push_data  = {w_push_rdata, w_push_err, r_dp_write};
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_ap_vld   <= 1'b0;
      r_ap_write <= 1'b0;
      r_ap_addr  <= '0;
      r_ap_wdata <= '0;
      r_dp_vld   <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_wdata <= '0;
    end else if (w_advance) begin
      r_dp_vld   <= r_ap_vld;
      r_dp_write <= r_ap_write;
      // HWDATA only moves for a real write; it holds otherwise.
      if (r_ap_vld && r_ap_write) r_dp_wdata <= r_ap_wdata;
      r_ap_vld   <= w_accept;
      // HADDR/HWRITE hold their last value while idle.
      if (w_accept) begin
        r_ap_write <= cmd_write;
        r_ap_addr  <= cmd_addr;
        r_ap_wdata <= cmd_wdata;
      end
    end
  end

  ahb_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH),
    .CNT_W (CNT_W)
  ) u_rsp_fifo (
    .i_clk   (HCLK),
    .i_rst_n (HRESETn),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (rsp_valid && rsp_ready),
    .o_rdata (w_head),
    .o_valid (rsp_valid),
    .o_count (w_fifo_count)
  );

  // Response fields read as zero while the FIFO is empty.
  assign rsp_rdata = rsp_valid ? w_head[RSP_W-1 -: DATA_W] : '0;
  assign rsp_err   = rsp_valid && w_head[TO_BIT+1];
  assign rsp_write = rsp_valid && w_head[TO_BIT];
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_valid && w_head[0];
`endif

  assign busy   = r_ap_vld || r_dp_vld;
  assign HTRANS = r_ap_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HSEL   = r_ap_vld;
  assign HADDR  = r_ap_addr;
  assign HWRITE = r_ap_write;
  assign HWDATA = r_dp_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_lite_master
//  Description : Self-checking bench for ahb_lite_master with a simple
//                zero/variable-wait-state memory slave. Addresses below 0x004
//                are read-only: writes there return HRESP = 1.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ahb_lite_master;
  import ahb_lite_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_write;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [9:0]  HADDR;
  logic [31:0] HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HSEL, HRESP, HREADY;
  logic        r_hready;

  always #5 HCLK = ~HCLK;

  ahb_lite_master dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_write (rsp_write),
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
    .rsp_timeout (),
`endif
    .busy      (busy),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSEL      (HSEL),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .HREADY    (HREADY)
  );

  // ---------------- memory slave ----------------
  logic [31:0] smem [1024];
  logic [31:0] rmem [1024];
  logic        s_vld, s_wr;
  logic [9:0]  s_addr;

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      s_vld <= 1'b0;
    end else if (r_hready) begin
      if (s_vld && s_wr && s_addr >= 10'd4) smem[s_addr] <= HWDATA;
      s_vld  <= HSEL && (HTRANS == 2'b10);
      s_wr   <= HWRITE;
      s_addr <= HADDR;
    end
  end

  always_comb begin
    HRDATA = 32'h0;
    if (s_vld && !s_wr) HRDATA = smem[s_addr];
  end
  assign HRESP  = s_vld && s_wr && (s_addr < 10'd4);
  assign HREADY = r_hready;

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // ---------------- scoreboard / monitor ----------------
  ahb_rsp_t    exp_q[$];
  logic [10:0] addr_q[$];
  ahb_rsp_t    m_e;
  logic [10:0] m_a;
  int n_acc = 0, n_rsp = 0, run = 0, max_run = 0;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      exp_q.delete();
      addr_q.delete();
      run = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        m_e.write = cmd_write;
        m_e.err   = cmd_write && (cmd_addr < 10'd4);
        m_e.rdata = cmd_write ? 32'h0 : rmem[cmd_addr];
        if (cmd_write && !m_e.err) rmem[cmd_addr] = cmd_wdata;
        exp_q.push_back(m_e);
        addr_q.push_back({cmd_write, cmd_addr});
        n_acc++;
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
        else begin
          m_e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, m_e.rdata);
          chk("rsp_err",   {31'd0, rsp_err},   {31'd0, m_e.err});
          chk("rsp_write", {31'd0, rsp_write}, {31'd0, m_e.write});
        end
      end
      if (HTRANS == 2'b10 && HREADY) begin
        if (addr_q.size() == 0) chk("addr_unexpected", 32'd1, 32'd0);
        else begin
          m_a = addr_q.pop_front();
          chk("haddr",  {22'd0, HADDR}, {22'd0, m_a[9:0]});
          chk("hwrite", {31'd0, HWRITE}, {31'd0, m_a[10]});
        end
      end
      if (HTRANS == 2'b10) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic w, input logic [9:0] a, input logic [31:0] d);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge HCLK);
      if (cmd_ready) begin ok = 1; break; end
    end
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  int a0, r0;
  logic [9:0]  snap_addr;
  logic [1:0]  snap_trans;
  logic [31:0] snap_wdata;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      smem[i] = 32'h5A00_0000 | i;
      rmem[i] = 32'h5A00_0000 | i;
    end
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b1; r_hready = 1'b1;
    idle(3);

    // Reset state
    @(negedge HCLK);
    chk("rst_htrans", {30'd0, HTRANS}, 32'd0);
    chk("rst_hsel",   {31'd0, HSEL},   32'd0);
    chk("rst_hwrite", {31'd0, HWRITE}, 32'd0);
    chk("rst_haddr",  {22'd0, HADDR},  32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    chk("rst_rsp_write", {31'd0, rsp_write}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    idle(1);
    HRESETn = 1'b1;
    idle(1);

    // Write then read back-to-back
    max_run = 0;
    send(1'b1, 10'h010, 32'hDEADBEEF);
    send(1'b0, 10'h010, 32'h0);
    idle(6);
    chk("wr_rd_nonseq_run", max_run, 32'd2);

    // Error write with latency check, then a clean read
    send(1'b1, 10'h002, 32'h12345678);
    @(negedge HCLK);
    chk("lat_htrans", {30'd0, HTRANS}, 32'd2);
    chk("lat_hsel",   {31'd0, HSEL},   32'd1);
    chk("lat_haddr",  {22'd0, HADDR},  32'h002);
    @(negedge HCLK);
    chk("lat_rsp_early", {31'd0, rsp_valid}, 32'd0);
    @(negedge HCLK);
    chk("lat_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("err_rsp_err",   {31'd0, rsp_err},   32'd1);
    chk("err_rsp_write", {31'd0, rsp_write}, 32'd1);
    idle(1);
    send(1'b0, 10'h005, 32'h0);
    idle(6);

    // Four-write burst
    max_run = 0; r0 = n_rsp;
    for (int i = 0; i < 4; i++) send(1'b1, 10'h020 + 10'(i), 32'hB000_0020 + i);
    idle(8);
    chk("burst_nonseq_run", max_run, 32'd4);
    chk("burst_rsp_count", n_rsp - r0, 32'd4);

    // Wait states mid-burst
    fork
      begin
        for (int i = 0; i < 4; i++) send(1'b1, 10'h030 + 10'(i), 32'hA000_0030 + i);
      end
      begin
        idle(3);
        r_hready = 1'b0;
        @(negedge HCLK);
        snap_addr = HADDR; snap_trans = HTRANS; snap_wdata = HWDATA;
        chk("stall_haddr_val",  {22'd0, HADDR}, 32'h032);
        chk("stall_hwdata_val", HWDATA, 32'hA000_0031);
        for (int i = 1; i < 3; i++) begin
          @(negedge HCLK);
          chk("stall_haddr",  {22'd0, HADDR}, {22'd0, snap_addr});
          chk("stall_htrans", {30'd0, HTRANS}, {30'd0, snap_trans});
          chk("stall_hwdata", HWDATA, snap_wdata);
          chk("stall_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge HCLK); #1;
        r_hready = 1'b1;
      end
    join
    idle(8);

    // Read back burst data
    send(1'b0, 10'h021, 32'h0);
    send(1'b0, 10'h033, 32'h0);
    idle(6);

    // Response backpressure: only RSP_DEPTH commands accepted
    rsp_ready = 1'b0; a0 = n_acc; r0 = n_rsp;
    fork
      begin
        for (int i = 0; i < 6; i++) send(i[0], 10'h020 + 10'(i), 32'hC000_0000 + i);
      end
      begin
        repeat (15) @(negedge HCLK);
        chk("bp_accepted",  n_acc - a0, 32'd4);
        chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge HCLK); #1;
        rsp_ready = 1'b1;
      end
    join
    idle(10);
    chk("bp_rsp_count", n_rsp - r0, 32'd6);

    // Reset during an outstanding read
    send(1'b0, 10'h010, 32'h0);
    HRESETn = 1'b0;
    idle(1);
    @(negedge HCLK);
    chk("mid_rst_htrans",    {30'd0, HTRANS},   32'd0);
    chk("mid_rst_hsel",      {31'd0, HSEL},     32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_busy",      {31'd0, busy},     32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    idle(1);
    send(1'b0, 10'h005, 32'h0);
    idle(6);

    chk("sb_empty",     exp_q.size(),  32'd0);
    chk("addr_q_empty", addr_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
